rf_scoreboard: RTL

Register file with an in-flight-write scoreboard for the 16-bit, 8-register pipelined core. It sits between decode and writeback. Decode presents the decoded `regWrite` bit and the destination register when an instruction issues, and writeback retires the write. The block gives two bypassed read ports and per-read-port "pending" flags that the hazard unit uses to stall.

---
 rtl/rf_scoreboard.sv | 120 ++++++++++++
 1 files changed

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: 8 x 16-bit register file with a per-register count of
// in-flight writes, used by the hazard unit to stall readers.
//
// Ports
//   clk, rst_n                     clock, async active-low reset
//   read1RegSel/read2RegSel        read port selects
//   read1Data/read2Data            combinational, writeback-bypassed read data
//   busy1/busy2                    selected register still has a writer pending
//                                  after this cycle's retirement
//   issue, issueRegSel             a regWrite instruction issues to issueRegSel
//   writeEn, writeRegSel, writeData  writeback retires a register write
//   err                            sticky over/underflow of a pending counter

// Per-register pending-write counter. fault pulses when the requested
// update would wrap; the counter then holds.
module rf_pend_cnt #(
    parameter int CNTW = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            inc,
    input  logic            dec,
    output logic [CNTW-1:0] pend,
    output logic            fault
);
    localparam logic [CNTW-1:0] MAX = '1;

    logic [CNTW-1:0] pend_d, pend_q;

    always_comb begin
        pend_d = pend_q;
        fault  = 1'b0;
        // inc and dec together cancel, legal at any count
        if (inc && !dec) begin
            if (pend_q == MAX) fault = 1'b1;
            else               pend_d = pend_q + CNTW'(1);
        end else if (dec && !inc) begin
            if (pend_q == '0)  fault = 1'b1;
            else               pend_d = pend_q - CNTW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pend_q <= '0;
        else        pend_q <= pend_d;
    end

    assign pend = pend_q;
endmodule

module rf_scoreboard #(
    parameter int WIDTH = 16,
    parameter int NREG  = 8,
    parameter int CNTW  = 2,
    localparam int SELW = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SELW-1:0]  read1RegSel,
    input  logic [SELW-1:0]  read2RegSel,
    output logic [WIDTH-1:0] read1Data,
    output logic [WIDTH-1:0] read2Data,
    output logic             busy1,
    output logic             busy2,
    input  logic             issue,
    input  logic [SELW-1:0]  issueRegSel,
    input  logic             writeEn,
    input  logic [SELW-1:0]  writeRegSel,
    input  logic [WIDTH-1:0] writeData,
    output logic             err
);
    logic [NREG-1:0][WIDTH-1:0] regs_d, regs_q;
    logic [NREG-1:0][CNTW-1:0]  pend;
    logic [NREG-1:0]            inc, dec, fault;
    logic                       err_d, err_q;
    logic                       byp1, byp2;

    for (genvar r = 0; r < NREG; r++) begin : g_cnt
        assign inc[r] = issue   && (issueRegSel == SELW'(r));
        assign dec[r] = writeEn && (writeRegSel == SELW'(r));
        rf_pend_cnt #(.CNTW(CNTW)) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (inc[r]),
            .dec   (dec[r]),
            .pend  (pend[r]),
            .fault (fault[r])
        );
    end

    always_comb begin
        regs_d = regs_q;
        if (writeEn) regs_d[writeRegSel] = writeData;
        err_d = err_q | (|fault);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= '0;
            err_q  <= 1'b0;
        end else begin
            regs_q <= regs_d;
            err_q  <= err_d;
        end
    end

    // Write-before-read: a retiring write is visible on the same cycle.
    assign byp1 = writeEn && (writeRegSel == read1RegSel);
    assign byp2 = writeEn && (writeRegSel == read2RegSel);

    assign read1Data = byp1 ? writeData : regs_q[read1RegSel];
    assign read2Data = byp2 ? writeData : regs_q[read2RegSel];

    // (pend - dec) != 0 rewritten as pend != dec. A same-cycle issue is a
    // younger writer and deliberately does not make the reader busy.
    assign busy1 = pend[read1RegSel] != CNTW'(byp1);
    assign busy2 = pend[read2RegSel] != CNTW'(byp2);

    assign err = err_q;
endmodule
